// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared memory-bus widths and request record
package mem_bus_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } mem_req_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered storage, no fall-through, push+pop honoured when full
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign cnt_d   = do_push && !do_pop ? cnt_q + 1'b1 : do_pop && !do_push ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= do_pop ? rptr_q + 1'b1 : rptr_q;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
  assign dout  = mem_q[rptr_q];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: valid/ready request stream to registered memory port, with credit-limited read response FIFO
module mem_req_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wr,
  input  logic [DATA_W-1:0] rddata
);
  localparam int CW = $clog2(RSP_DEPTH+1);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic wr_q, wr_d;
  logic [RD_LAT:0] tag_q, tag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc, rd_acc, pop, empty, unused_full;
  logic [CW-1:0] unused_count;
  assign req_ready = !rst && cnt_q < CW'(RSP_DEPTH);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_wr;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = !empty;
  always_comb begin
    addr_d   = acc ? req_addr : addr_q;
    wrdata_d = acc && req_wr ? req_wdata : wrdata_q;
    wr_d     = acc && req_wr;
    tag_d    = {tag_q[RD_LAT-1:0], rd_acc};
    cnt_d    = rd_acc && !pop ? cnt_q + 1'b1 : pop && !rd_acc ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wrdata_q <= '0;
      wr_q     <= 1'b0;
      tag_q    <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wr_q     <= wr_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
    end
  end
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wr     = wr_q;
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_q[RD_LAT]),
    .din   (rddata),
    .pop   (pop),
    .dout  (rsp_rdata),
    .full  (unused_full),
    .empty (empty),
    .count (unused_count)
  );
endmodule

// File: tb/tb_mem_req_bridge.sv
// tb_mem_req_bridge: table-driven and randomized checks of mem_req_bridge against a queue-based model
module tb_mem_req_bridge;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, wr;
  logic [31:0] req_addr, req_wdata, rsp_rdata, addr, wrdata, rddata;
  always #5 clk = ~clk;
  mem_req_bridge dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .addr(addr), .wrdata(wrdata), .wr(wr), .rddata(rddata)
  );
  function automatic logic [31:0] init_val(int i);
    return i < 8 ? 32'h100 + 32'(i) : 32'hC0DE_0000 + 32'(i);
  endfunction
  logic init_mem;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (wr) mem[addr[7:0]] <= wrdata;
      rddata <= mem[addr[7:0]];
    end
  end
  typedef struct {
    logic rst, v, w;
    logic [31:0] a, d;
    logic rr, chk, e_rdy, e_wr;
    logic [31:0] e_addr;
    logic e_val;
    logic [31:0] e_rdata;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    int en;
  } rsp_t;
  rsp_t q[$];
  logic [31:0] shadow [256];
  logic m_wr;
  logic [31:0] m_addr, m_wrdata;
  int ncyc, nvec, nmis, nacc;
  vec_t tbl [18];
  function automatic vec_t row(input logic r, v, w, input logic [31:0] a, d, input logic rr,
                               input logic er, ew, input logic [31:0] ea, input logic ev, input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr; t.chk = 1'b1;
    t.e_rdy = er; t.e_wr = ew; t.e_addr = ea; t.e_val = ev; t.e_rdata = ed;
    return t;
  endfunction
  function automatic vec_t io(input logic r, v, w, input logic [31:0] a, d, input logic rr);
    vec_t t;
    t = row(r, v, w, a, d, rr, L, L, 0, L, 0);
    t.chk = 1'b0;
    return t;
  endfunction
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, ncyc, act, exp);
    end
  endtask
  task automatic apply(input vec_t t);
    logic er, ev;
    @(negedge clk);
    rst = t.rst; req_valid = t.v; req_wr = t.w; req_addr = t.a; req_wdata = t.d; rsp_ready = t.rr;
    #1;
    er = !t.rst && q.size() < 4;
    ev = q.size() > 0 && q[0].en + 2 <= ncyc;
    cmp("req_ready", req_ready, er);
    cmp("rsp_valid", rsp_valid, ev);
    if (ev) cmp("rsp_rdata", rsp_rdata, q[0].data);
    cmp("wr", wr, m_wr);
    cmp("addr", addr, m_addr);
    if (m_wr) cmp("wrdata", wrdata, m_wrdata);
    if (t.chk) begin
      cmp("tbl_ready", req_ready, t.e_rdy);
      cmp("tbl_wr", wr, t.e_wr);
      cmp("tbl_addr", addr, t.e_addr);
      cmp("tbl_rsp_valid", rsp_valid, t.e_val);
      if (t.e_val) cmp("tbl_rsp_rdata", rsp_rdata, t.e_rdata);
    end
    if (t.v && req_ready) nacc++;
    if (t.rst) begin
      q.delete();
      m_wr = 1'b0; m_addr = '0; m_wrdata = '0;
    end else begin
      if (ev && t.rr) void'(q.pop_front());
      if (t.v && er) begin
        if (t.w) begin
          shadow[t.a[7:0]] = t.d;
          m_wrdata = t.d;
        end else q.push_back('{shadow[t.a[7:0]], ncyc + 1});
        m_addr = t.a;
      end
      m_wr = t.v && er && t.w;
    end
    @(posedge clk);
    ncyc++;
  endtask
  initial begin
    nvec = 0; nmis = 0; ncyc = 0; nacc = 0;
    m_wr = 1'b0; m_addr = '0; m_wrdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    tbl[0]  = row(H, H, H, 3, 0, L,            L, L, 0, L, 0);
    tbl[1]  = row(H, H, H, 3, 0, L,            L, L, 0, L, 0);
    tbl[2]  = row(H, H, H, 3, 0, L,            L, L, 0, L, 0);
    tbl[3]  = row(L, H, H, 3, 32'hA5A5_0001, H, H, L, 0, L, 0);
    tbl[4]  = row(L, L, L, 0, 0, H,            H, H, 3, L, 0);
    tbl[5]  = row(L, H, L, 3, 0, H,            H, L, 3, L, 0);
    tbl[6]  = row(L, L, L, 0, 0, H,            H, L, 3, L, 0);
    tbl[7]  = row(L, L, L, 0, 0, H,            H, L, 3, L, 0);
    tbl[8]  = row(L, L, L, 0, 0, H,            H, L, 3, H, 32'hA5A5_0001);
    tbl[9]  = row(L, L, L, 0, 0, H,            H, L, 3, L, 0);
    tbl[10] = row(L, H, H, 5, 32'h55, H,       H, L, 3, L, 0);
    tbl[11] = row(L, H, L, 5, 0, H,            H, H, 5, L, 0);
    tbl[12] = row(L, H, H, 5, 32'h66, H,       H, L, 5, L, 0);
    tbl[13] = row(L, H, L, 5, 0, H,            H, H, 5, L, 0);
    tbl[14] = row(L, L, L, 0, 0, H,            H, L, 5, H, 32'h55);
    tbl[15] = row(L, L, L, 0, 0, H,            H, L, 5, L, 0);
    tbl[16] = row(L, L, L, 0, 0, H,            H, L, 5, H, 32'h66);
    tbl[17] = row(L, L, L, 0, 0, H,            H, L, 5, L, 0);
    init_mem = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    apply(io(H, L, L, 0, 0, L));
    nacc = 0;
    for (int i = 0; i < 8; i++) apply(io(L, H, L, i, 0, H));
    cmp("b2b_accepts", nacc, 8);
    repeat (5) apply(io(L, L, L, 0, 0, H));
    nacc = 0;
    for (int i = 0; i < 8; i++) apply(io(L, H, L, i, 0, L));
    cmp("stall_accepts", nacc, 4);
    nacc = 0;
    apply(io(L, H, L, 1, 0, H));
    for (int i = 0; i < 4; i++) apply(io(L, H, L, 2 + i, 0, L));
    cmp("credit_accepts", nacc, 1);
    repeat (10) apply(io(L, L, L, 0, 0, H));
    apply(io(H, L, L, 0, 0, L));
    for (int i = 0; i < 18; i++) apply(tbl[i]);
    for (int i = 0; i < 3; i++) apply(io(L, H, L, i, 0, L));
    apply(io(H, L, L, 0, 0, H));
    repeat (4) apply(io(L, L, L, 0, 0, H));
    apply(io(L, H, L, 6, 0, H));
    repeat (4) apply(io(L, L, L, 0, 0, H));
    for (int i = 0; i < 400; i++)
      apply(io($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 15)),
               $urandom, $urandom_range(0, 3) != 0));
    repeat (8) apply(io(L, L, L, 0, 0, H));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
